// File: rtl/i2c_slave_if.sv
// Host-side bundle of the I2C target: byte exchange and transaction status.
interface i2c_slave_if;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_hit;
  logic       rw;
  logic       busy;

  modport slave  (input tx_data, output tx_req, rx_data, rx_valid, addr_hit, rw, busy);
  modport master (output tx_data, input tx_req, rx_data, rx_valid, addr_hit, rw, busy);
endinterface

// File: rtl/i2c_slave.sv
// 7-bit address I2C target, oversampled on clk100mhz; SDA is only ever pulled low or released.
// Optional spike filter on SCL/SDA enabled by defining I2C_SLV_FILTER_EN.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h4C,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 4
) (
  input  logic        clk100mhz,
  input  logic        res,
  input  logic        scl,
  inout  wire         sda,
  i2c_slave_if.slave  host
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_DATA   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_DATA   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_in_s, sda_in_s;
  logic scl_dly_q, sda_dly_q;
  logic scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       ack_phase_q, ack_phase_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       addr_hit_q, addr_hit_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;

  // Synchronizer shift for both bus lines
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
  end

`ifdef I2C_SLV_FILTER_EN
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  logic          scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
  logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

  // A line only flips after FILT_LEN consecutive samples disagree with it
  always_comb begin
    scl_filt_d = scl_filt_q;
    sda_filt_d = sda_filt_q;
    scl_cnt_d  = {CW{1'b0}};
    sda_cnt_d  = {CW{1'b0}};
    if (scl_sync_q[SYNC_STAGES-1] != scl_filt_q) begin
      if (scl_cnt_q == CW'(FILT_LEN - 1)) scl_filt_d = scl_sync_q[SYNC_STAGES-1];
      else                                scl_cnt_d  = scl_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      scl_cnt_d = {CW{1'b0}};
    end
    if (sda_sync_q[SYNC_STAGES-1] != sda_filt_q) begin
      if (sda_cnt_q == CW'(FILT_LEN - 1)) sda_filt_d = sda_sync_q[SYNC_STAGES-1];
      else                                sda_cnt_d  = sda_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      sda_cnt_d = {CW{1'b0}};
    end
  end

  // Filter state
  always_ff @(posedge clk100mhz) begin
    if (!res) begin
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_cnt_q  <= {CW{1'b0}};
      sda_cnt_q  <= {CW{1'b0}};
    end else begin
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
    end
  end

  assign scl_in_s = scl_filt_q;
  assign sda_in_s = sda_filt_q;
`else
  assign scl_in_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_in_s = sda_sync_q[SYNC_STAGES-1];
`endif

  assign scl_rise_s = scl_in_s & ~scl_dly_q;
  assign scl_fall_s = ~scl_in_s & scl_dly_q;
  assign start_s    = scl_in_s & scl_dly_q & ~sda_in_s & sda_dly_q;
  assign stop_s     = scl_in_s & scl_dly_q & sda_in_s & ~sda_dly_q;

  // Protocol FSM; START/STOP override whatever bit handling is in progress
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_shift_d  = tx_shift_q;
    sda_oe_d    = sda_oe_q;
    ack_phase_d = ack_phase_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    addr_hit_d  = addr_hit_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    if (start_s) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      sda_oe_d    = 1'b0;
      ack_phase_d = 1'b0;
      addr_hit_d  = 1'b0;
      busy_d      = 1'b1;
    end else if (stop_s) begin
      state_d    = ST_IDLE;
      sda_oe_d   = 1'b0;
      addr_hit_d = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: sda_oe_d = 1'b0;
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d   = {shift_q[5:0], sda_in_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_q == SLAVE_ADDR) begin
                rw_d        = sda_in_s;
                ack_phase_d = 1'b0;
                state_d     = ST_ADDR_ACK;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            if (!ack_phase_q) begin
              sda_oe_d    = 1'b1;
              addr_hit_d  = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              ack_phase_d = 1'b0;
              bit_cnt_d   = 3'd0;
              if (rw_q) begin
                tx_req_d   = 1'b1;
                tx_shift_d = host.tx_data[6:0];
                sda_oe_d   = ~host.tx_data[7];
                state_d    = ST_RD_DATA;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_WR_DATA;
              end
            end
          end else begin
            state_d = ST_ADDR_ACK;
          end
        end
        ST_WR_DATA: begin
          if (scl_rise_s) begin
            shift_d   = {shift_q[5:0], sda_in_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d   = {shift_q, sda_in_s};
              rx_valid_d  = 1'b1;
              ack_phase_d = 1'b0;
              state_d     = ST_WR_ACK;
            end else begin
              state_d = ST_WR_DATA;
            end
          end else begin
            state_d = ST_WR_DATA;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall_s) begin
            if (!ack_phase_q) begin
              sda_oe_d    = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              sda_oe_d    = 1'b0;
              ack_phase_d = 1'b0;
              state_d     = ST_WR_DATA;
            end
          end else begin
            state_d = ST_WR_ACK;
          end
        end
        ST_RD_DATA: begin
          if (scl_fall_s) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = ST_RD_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 3'd1;
            end
          end else begin
            state_d = ST_RD_DATA;
          end
        end
        // A NACK on the rise ends the read; otherwise the next fall loads the next byte
        ST_RD_ACK: begin
          if (scl_rise_s && sda_in_s) begin
            state_d = ST_WAIT_STOP;
          end else if (scl_fall_s) begin
            tx_req_d   = 1'b1;
            tx_shift_d = host.tx_data[6:0];
            sda_oe_d   = ~host.tx_data[7];
            bit_cnt_d  = 3'd0;
            state_d    = ST_RD_DATA;
          end else begin
            state_d = ST_RD_ACK;
          end
        end
        ST_WAIT_STOP: sda_oe_d = 1'b0;
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk100mhz) begin
    if (!res) begin
      scl_sync_q  <= {SYNC_STAGES{1'b1}};
      sda_sync_q  <= {SYNC_STAGES{1'b1}};
      scl_dly_q   <= 1'b1;
      sda_dly_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      tx_shift_q  <= 7'd0;
      sda_oe_q    <= 1'b0;
      ack_phase_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      addr_hit_q  <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_dly_q   <= scl_in_s;
      sda_dly_q   <= sda_in_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_shift_q  <= tx_shift_d;
      sda_oe_q    <= sda_oe_d;
      ack_phase_q <= ack_phase_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      addr_hit_q  <= addr_hit_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
    end
  end

  assign sda           = sda_oe_q ? 1'b0 : 1'bz;
  assign host.tx_req   = tx_req_q;
  assign host.rx_data  = rx_data_q;
  assign host.rx_valid = rx_valid_q;
  assign host.addr_hit = addr_hit_q;
  assign host.rw       = rw_q;
  assign host.busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: bit-banged I2C master plus a byte scoreboard.
module tb_i2c_slave;
  localparam int Q = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic res;
  logic m_scl;
  logic m_sda_low;
  wire  sda;
  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_if host_if();

  i2c_slave dut (
    .clk100mhz (clk),
    .res       (res),
    .scl       (m_scl),
    .sda       (sda),
    .host      (host_if)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] rd_exp_q[$];
  int rx_cnt = 0;
  int rx_extra = 0;
  int tx_req_cnt = 0;
  int busy_drops = 0;
  bit watch_busy = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Output monitor: pops the write scoreboard on every rx_valid pulse
  always @(negedge clk) begin
    if (host_if.rx_valid) begin
      rx_cnt++;
      if (rx_exp_q.size() > 0) check_eq("rx_data", 32'(host_if.rx_data), 32'(rx_exp_q.pop_front()));
      else rx_extra++;
    end
    if (host_if.tx_req) tx_req_cnt++;
    if (watch_busy && !host_if.busy) busy_drops++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_clk(Q);
    m_scl = 1'b1;     wait_clk(Q);
    m_sda_low = 1'b1; wait_clk(Q);
    m_scl = 1'b0;     wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_clk(Q);
    m_scl = 1'b1;     wait_clk(Q);
    m_sda_low = 1'b0; wait_clk(Q);
  endtask

  task automatic bit_out(input logic b, output logic s);
    m_sda_low = ~b; wait_clk(Q);
    m_scl = 1'b1;   wait_clk(Q);
    s = sda;        wait_clk(Q);
    m_scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(b[i], s);
    bit_out(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_ack, input logic [7:0] next_tx, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_out(1'b1, s);
      b[i] = s;
    end
    host_if.tx_data = next_tx;
    bit_out(~master_ack, s);
  endtask

  initial begin
    logic ack;
    logic s;
    logic [7:0] b;
    int c0;
    bit seen;

    res = 1'b0; m_scl = 1'b1; m_sda_low = 1'b0; host_if.tx_data = 8'h00;
    wait_clk(5);
    check_eq("rst_busy", 32'(host_if.busy), 32'd0);
    check_eq("rst_addr_hit", 32'(host_if.addr_hit), 32'd0);
    check_eq("rst_rw", 32'(host_if.rw), 32'd0);
    check_eq("rst_tx_req", 32'(host_if.tx_req), 32'd0);
    check_eq("rst_rx_valid", 32'(host_if.rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(host_if.rx_data), 32'h00);
    check_eq("rst_sda", 32'(sda), 32'd1);
    res = 1'b1;
    wait_clk(5);

    // 1: write 0x55 to own address
    c0 = rx_cnt;
    i2c_start();
    check_eq("t1_busy", 32'(host_if.busy), 32'd1);
    write_byte(8'h98, ack);
    check_eq("t1_addr_ack", 32'(ack), 32'd0);
    check_eq("t1_addr_hit", 32'(host_if.addr_hit), 32'd1);
    check_eq("t1_rw", 32'(host_if.rw), 32'd0);
    rx_exp_q.push_back(8'h55);
    write_byte(8'h55, ack);
    check_eq("t1_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(Q);
    check_eq("t1_rx_pulses", 32'(rx_cnt - c0), 32'd1);
    check_eq("t1_addr_hit_end", 32'(host_if.addr_hit), 32'd0);
    check_eq("t1_busy_end", 32'(host_if.busy), 32'd0);

    // 2: foreign address is ignored
    c0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check_eq("t2_addr_nack", 32'(ack), 32'd1);
    check_eq("t2_addr_hit", 32'(host_if.addr_hit), 32'd0);
    write_byte(8'h77, ack);
    check_eq("t2_data_nack", 32'(ack), 32'd1);
    i2c_stop();
    wait_clk(Q);
    check_eq("t2_rx_pulses", 32'(rx_cnt - c0), 32'd0);

    // 3: read two bytes, ACK then NACK
    host_if.tx_data = 8'hA5;
    rd_exp_q.push_back(8'hA5);
    rd_exp_q.push_back(8'h3C);
    c0 = tx_req_cnt;
    i2c_start();
    write_byte(8'h99, ack);
    check_eq("t3_addr_ack", 32'(ack), 32'd0);
    check_eq("t3_rw", 32'(host_if.rw), 32'd1);
    read_byte(1'b1, 8'h3C, b);
    check_eq("t3_byte0", 32'(b), 32'(rd_exp_q.pop_front()));
    read_byte(1'b0, 8'h00, b);
    check_eq("t3_byte1", 32'(b), 32'(rd_exp_q.pop_front()));
    check_eq("t3_tx_req_pulses", 32'(tx_req_cnt - c0), 32'd2);
    bit_out(1'b1, s);
    check_eq("t3_released", 32'(s), 32'd1);
    i2c_stop();
    wait_clk(Q);

    // 4: write then repeated START into a read, no STOP in between
    c0 = tx_req_cnt;
    i2c_start();
    watch_busy = 1'b1;
    write_byte(8'h98, ack);
    check_eq("t4_waddr_ack", 32'(ack), 32'd0);
    rx_exp_q.push_back(8'h12);
    write_byte(8'h12, ack);
    check_eq("t4_wdata_ack", 32'(ack), 32'd0);
    check_eq("t4_rw_wr", 32'(host_if.rw), 32'd0);
    i2c_start();
    check_eq("t4_addr_hit_rs", 32'(host_if.addr_hit), 32'd0);
    host_if.tx_data = 8'h5A;
    rd_exp_q.push_back(8'h5A);
    write_byte(8'h99, ack);
    check_eq("t4_raddr_ack", 32'(ack), 32'd0);
    check_eq("t4_rw_rd", 32'(host_if.rw), 32'd1);
    check_eq("t4_rx_data", 32'(host_if.rx_data), 32'h12);
    read_byte(1'b0, 8'h00, b);
    check_eq("t4_rbyte", 32'(b), 32'(rd_exp_q.pop_front()));
    watch_busy = 1'b0;
    check_eq("t4_busy_drops", 32'(busy_drops), 32'd0);
    check_eq("t4_tx_req_pulses", 32'(tx_req_cnt - c0), 32'd1);
    i2c_stop();
    wait_clk(Q);

    // 5: reset while the address ACK holds SDA low
    c0 = rx_cnt;
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_out(b[i] & 1'b0 | (8'h98 >> i) & 8'h01, s);
    m_sda_low = 1'b0;
    wait_clk(1);
    check_eq("t5_ack_drive", 32'(sda), 32'd0);
    res = 1'b0;
    wait_clk(1);
    res = 1'b1;
    check_eq("t5_sda_rel", 32'(sda), 32'd1);
    check_eq("t5_busy", 32'(host_if.busy), 32'd0);
    check_eq("t5_addr_hit", 32'(host_if.addr_hit), 32'd0);
    check_eq("t5_rx_data", 32'(host_if.rx_data), 32'h00);
    bit_out(1'b1, s);
    write_byte(8'h55, ack);
    check_eq("t5_ignored_ack", 32'(ack), 32'd1);
    check_eq("t5_rx_pulses", 32'(rx_cnt - c0), 32'd0);
    i2c_stop();
    wait_clk(Q);

    // 6: 2-clock SDA glitch while SCL is high
    seen = 1'b0;
    m_sda_low = 1'b1;
    wait_clk(2);
    m_sda_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host_if.busy) seen = 1'b1;
    end
`ifdef I2C_SLV_FILTER_EN
    check_eq("t6_glitch_start", 32'(seen), 32'd0);
`else
    check_eq("t6_glitch_start", 32'(seen), 32'd1);
`endif
    check_eq("t6_busy_end", 32'(host_if.busy), 32'd0);

    check_eq("rx_queue_left", 32'(rx_exp_q.size()), 32'd0);
    check_eq("rx_unexpected", 32'(rx_extra), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
7-bit-address I2C target that answers the team's i2c_master on the same open-drain SDA/SCL pair. It oversamples SCL/SDA on the 100 MHz system clock and detects START, STOP and repeated START. On a write it ACKs its own address and receives data bytes. On a read it shifts out bytes supplied by the host logic.

Parameters:
SLAVE_ADDR, 7'h4C, own 7-bit address; address byte 8'b1001_1001 = 7'h4C + R/W=1.
SYNC_STAGES, 2, synchronizer depth on SCL/SDA inputs (min 2).
FILT_LEN, 4, glitch-filter length in clk100mhz cycles (used only with I2C_SLV_FILTER_EN).

Ports:
clk100mhz  input  1  system clock, 100 MHz.
res  input  1  synchronous reset, active-low.
scl  input  1  I2C clock from master (never driven by this block).
sda  inout  1  I2C data; driven 1'b0 or 1'bz only, never 1.
tx_data  input  8  byte to return on read; sampled when tx_req pulses.
tx_req  output  1  one-cycle pulse: tx_data is being latched into the shift register.
rx_data  output  8  last byte received on write.
rx_valid  output  1  one-cycle pulse when rx_data updates.
addr_hit  output  1  high from own-address ACK until STOP or repeated START.
rw  output  1  R/W bit of current transaction (1 = read).
busy  output  1  high from START to STOP (any address).

Behaviour:
- Reset (res=0 at a clk100mhz edge): sda released (Z); tx_req, rx_valid, addr_hit, rw, busy = 0; rx_data = 8'h00; state IDLE; bit counter 0.
- Inputs pass through SYNC_STAGES flops, then a 1-cycle-delayed copy for edge detect. Pin-to-event latency = SYNC_STAGES+1 clocks.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are checked every cycle and take priority over bit processing.
  - START in any state: state ADDR, bit count 0, sda released, addr_hit=0, busy=1.
  - STOP in any state: state IDLE, sda released, addr_hit=0, busy=0.
- Data is sampled on the SCL rising edge. The sda enable changes only on the SCL falling edge, so SDA is stable while SCL is high.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first. After the 8th rise, compare bits[7:1] with SLAVE_ADDR.
    - Match: rw=bit0, go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP.
  - ADDR_ACK: on the next SCL fall, drive 0 and set addr_hit=1. On the following fall, release.
    - rw=0: go to WR_DATA.
    - rw=1: pulse tx_req, load tx_data, drive its MSB (0 drives low, 1 releases) in the same cycle, go to RD_DATA.
  - WR_DATA: shift 8 bits. After the 8th rise, rx_data updates and rx_valid pulses in the same cycle; go to WR_ACK.
  - WR_ACK: drive 0 from the next fall to the following fall, then return to WR_DATA. Bytes are unlimited; the byte counter wraps.
  - RD_DATA: on each fall present the next bit. After 8 bits, release on the 8th fall; go to RD_ACK.
  - RD_ACK: sample SDA on the rise.
    - 0 (ACK): on the fall, pulse tx_req, load the next byte, go to RD_DATA.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: sda released; wait for STOP or START.
- Bit counter is 3 bits and wraps 7->0 at each byte boundary.
- tx_data must be stable in the cycle tx_req is high.
- SCL stretching is not supported.

Optional Feature:
I2C_SLV_FILTER_EN.
- Defined: after the synchronizers, each of SCL and SDA is a FILT_LEN-sample majority/hold filter. The output changes only after FILT_LEN consecutive equal samples, suppressing spikes shorter than FILT_LEN clocks; latency grows by FILT_LEN.
- Undefined: synchronizer output is used directly, and any pulse of at least 1 clock is seen.

Test Plan:
1. START, addr byte 8'b1001_1000 (0x4C, write), data 8'h55, STOP -> SDA low during both ACK slots; rx_data=8'h55; rx_valid one pulse; addr_hit 1 then 0 after STOP; busy deasserts.
2. START, addr 8'b1010_0000 -> no ACK (SDA high at 9th rise), addr_hit stays 0, no rx_valid; block ignores the rest until STOP.
3. START, addr 8'b1001_1001 (read), tx_data=8'hA5, master ACKs the first byte then NACKs the second (tx_data=8'h3C) -> SDA bits 10100101 then 00111100; tx_req pulses twice; SDA released after NACK.
4. Write 8'h12, then repeated START with read address, no STOP -> rx_data=8'h12, rw goes 0->1, busy stays 1 throughout.
5. res low for 1 clock mid-ACK while SDA is driven low -> SDA released on the next clock, all outputs at reset values, block ignores bits until the next START.
6. With I2C_SLV_FILTER_EN: a 2-clock SDA low glitch while SCL is high -> no START detected, state unchanged. Without it: START detected.
